// File: rtl/regfile_if.sv
// -----------------------------------------------------------------------------
// regfile_if
// Purpose : Bundles the write port and the two read ports of regfile_2r1w.
// Signals :
//    write       1      write enable, sampled on rising clk
//    writenum    AW     write address
//    data_in     WIDTH  write data
//    readnum_a   AW     read address, port A
//    readnum_b   AW     read address, port B
//    data_out_a  WIDTH  read data, port A (combinational)
//    data_out_b  WIDTH  read data, port B (combinational)
//    valid_a     1      written flag of the register addressed on port A
//    valid_b     1      written flag of the register addressed on port B
//    written     DEPTH  per-register written flags, bit i = register i
// Modports: master = datapath driving addresses/data, slave = register file.
// -----------------------------------------------------------------------------
interface regfile_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
);
   logic             write;
   logic [AW-1:0]    writenum;
   logic [WIDTH-1:0] data_in;
   logic [AW-1:0]    readnum_a;
   logic [AW-1:0]    readnum_b;
   logic [WIDTH-1:0] data_out_a;
   logic [WIDTH-1:0] data_out_b;
   logic             valid_a;
   logic             valid_b;
   logic [DEPTH-1:0] written;

   modport master (
      output write, writenum, data_in, readnum_a, readnum_b,
      input  data_out_a, data_out_b, valid_a, valid_b, written
   );

   modport slave (
      input  write, writenum, data_in, readnum_a, readnum_b,
      output data_out_a, data_out_b, valid_a, valid_b, written
   );
endinterface

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Purpose : Parametrised register file with one write port and two independent
//           combinational read ports. Each register carries a written flag.
//           Optional same-cycle write-to-read bypass and hardwired-zero R0.
// Ports   :
//    clk    input   rising-edge clock
//    reset  input   synchronous, active-high reset
//    rf     slave   regfile_if: write port, read ports A/B, written flags
// Parameters: WIDTH, DEPTH (2..256), AW (2**AW >= DEPTH), BYPASS, ZERO_REG
// -----------------------------------------------------------------------------
module regfile_2r1w #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AW       = 3,
   parameter bit BYPASS   = 1'b0,
   parameter bit ZERO_REG = 1'b0
) (
   input  logic     clk,
   input  logic     reset,
   regfile_if.slave rf
);

   // Flag bit forced on for register 0 when it is hardwired to zero.
   localparam logic [DEPTH-1:0] ZERO_MASK = ZERO_REG ? DEPTH'(1) : '0;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] written_q;
   logic [DEPTH-1:0] written_d;
   logic [DEPTH-1:0] flags;
   logic             wr_en;

   // A write lands only on an in-range, writable register. Reset is left out
   // on purpose: it wins at the edge, and keeping it out of this term keeps
   // reset off every combinational path to the read outputs.
   assign wr_en = rf.write
                  && (int'(rf.writenum) < DEPTH)
                  && !(ZERO_REG && (rf.writenum == '0));

   // NOTE: every variable assigned in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      written_d = written_q;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (wr_en && (rf.writenum == AW'(i))) begin
            mem_d[i]     = rf.data_in;
            written_d[i] = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge value, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the array is cleared on reset because a read of a register
         // right after reset must return 0, not leftover contents.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         written_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         written_q <= written_d;
      end
   end

   // R0 never accepts a write when hardwired, so its storage stays 0 from
   // reset; only its flag needs forcing.
   assign flags      = written_q | ZERO_MASK;
   assign rf.written = flags;

   // Read ports: out-of-range addresses match no register and fall through
   // to the 0 / not-valid defaults.
   always_comb begin
      rf.data_out_a = '0;
      rf.data_out_b = '0;
      rf.valid_a    = 1'b0;
      rf.valid_b    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rf.readnum_a == AW'(i)) begin
            rf.data_out_a = mem_q[i];
            rf.valid_a    = flags[i];
         end
         if (rf.readnum_b == AW'(i)) begin
            rf.data_out_b = mem_q[i];
            rf.valid_b    = flags[i];
         end
      end
      if (BYPASS && wr_en) begin
         if (rf.readnum_a == rf.writenum) begin
            rf.data_out_a = rf.data_in;
            rf.valid_a    = 1'b1;
         end
         if (rf.readnum_b == rf.writenum) begin
            rf.data_out_b = rf.data_in;
            rf.valid_b    = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
// Purpose : Directed self-checking bench for regfile_2r1w. Two instances:
//           u_dut0 uses the defaults (DEPTH=8, no bypass, no zero register),
//           u_dut1 uses DEPTH=6, BYPASS=1, ZERO_REG=1.
// Ports   : none (top-level bench).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_2r1w;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   regfile_if #(.WIDTH(16), .DEPTH(8), .AW(3)) if0 ();
   regfile_if #(.WIDTH(16), .DEPTH(6), .AW(3)) if1 ();

   regfile_2r1w #(
      .WIDTH(16), .DEPTH(8), .AW(3), .BYPASS(1'b0), .ZERO_REG(1'b0)
   ) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .rf    (if0.slave)
   );

   regfile_2r1w #(
      .WIDTH(16), .DEPTH(6), .AW(3), .BYPASS(1'b1), .ZERO_REG(1'b1)
   ) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .rf    (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are
   // sampled 1 ns later, well away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      if0.write = 1'b0; if0.writenum = '0; if0.data_in = '0;
      if0.readnum_a = '0; if0.readnum_b = '0;
      if1.write = 1'b0; if1.writenum = '0; if1.data_in = '0;
      if1.readnum_a = '0; if1.readnum_b = '0;

      // 1. Reset, then sweep all addresses.
      tick();
      reset = 1'b0;
      #1;
      for (int i = 0; i < 8; i++) begin
         if0.readnum_a = 3'(i);
         if0.readnum_b = 3'(7 - i);
         #1;
         check($sformatf("rst0_data_a[%0d]", i), 32'(if0.data_out_a), 32'h0);
         check($sformatf("rst0_data_b[%0d]", 7 - i), 32'(if0.data_out_b), 32'h0);
         check($sformatf("rst0_valid_a[%0d]", i), 32'(if0.valid_a), 32'h0);
         check($sformatf("rst0_valid_b[%0d]", 7 - i), 32'(if0.valid_b), 32'h0);
      end
      check("rst0_written", 32'(if0.written), 32'h00);
      check("rst1_written", 32'(if1.written), 32'h01);
      if1.readnum_a = 3'd0;
      if1.readnum_b = 3'd4;
      #1;
      check("rst1_r0_data", 32'(if1.data_out_a), 32'h0);
      check("rst1_r0_valid", 32'(if1.valid_a), 32'h1);
      check("rst1_r4_valid", 32'(if1.valid_b), 32'h0);

      // 2. Write R3 and R5 on consecutive edges, read both ports.
      if0.write = 1'b1; if0.writenum = 3'd3; if0.data_in = 16'h00A5;
      tick();
      if0.writenum = 3'd5; if0.data_in = 16'h1234;
      tick();
      if0.write = 1'b0;
      if0.readnum_a = 3'd3; if0.readnum_b = 3'd5;
      #1;
      check("wr_data_a_r3", 32'(if0.data_out_a), 32'h00A5);
      check("wr_data_b_r5", 32'(if0.data_out_b), 32'h1234);
      check("wr_valid_a", 32'(if0.valid_a), 32'h1);
      check("wr_valid_b", 32'(if0.valid_b), 32'h1);
      check("wr_written", 32'(if0.written), 32'h28);
      if0.readnum_b = 3'd3;
      #1;
      check("same_reg_b_r3", 32'(if0.data_out_b), 32'h00A5);

      // 3. Write R2 while reading it: old value without bypass, new with it.
      if0.write = 1'b1; if0.writenum = 3'd2; if0.data_in = 16'hBEEF;
      if0.readnum_a = 3'd2;
      if1.write = 1'b1; if1.writenum = 3'd2; if1.data_in = 16'hBEEF;
      if1.readnum_a = 3'd2; if1.readnum_b = 3'd3;
      #1;
      check("nobyp_pre_data", 32'(if0.data_out_a), 32'h0000);
      check("nobyp_pre_valid", 32'(if0.valid_a), 32'h0);
      check("byp_pre_data_a", 32'(if1.data_out_a), 32'hBEEF);
      check("byp_pre_valid_a", 32'(if1.valid_a), 32'h1);
      check("byp_other_b_data", 32'(if1.data_out_b), 32'h0000);
      check("byp_other_b_valid", 32'(if1.valid_b), 32'h0);
      if1.readnum_b = 3'd2;
      #1;
      check("byp_pre_data_b", 32'(if1.data_out_b), 32'hBEEF);
      tick();
      if0.write = 1'b0;
      if1.write = 1'b0;
      #1;
      check("nobyp_post_data", 32'(if0.data_out_a), 32'hBEEF);
      check("nobyp_post_valid", 32'(if0.valid_a), 32'h1);
      check("byp_post_data", 32'(if1.data_out_a), 32'hBEEF);

      // 4. Hardwired R0 ignores a write, also on the bypass path.
      if1.write = 1'b1; if1.writenum = 3'd0; if1.data_in = 16'hFFFF;
      if1.readnum_a = 3'd0;
      #1;
      check("zero_pre_data", 32'(if1.data_out_a), 32'h0000);
      tick();
      if1.write = 1'b0;
      #1;
      check("zero_post_data", 32'(if1.data_out_a), 32'h0000);
      check("zero_post_valid", 32'(if1.valid_a), 32'h1);
      check("zero_written", 32'(if1.written), 32'h05);

      // 5. Out-of-range write on DEPTH=6 changes nothing.
      if1.write = 1'b1; if1.writenum = 3'd7; if1.data_in = 16'h7777;
      if1.readnum_a = 3'd6; if1.readnum_b = 3'd7;
      #1;
      check("oor_pre_data_b", 32'(if1.data_out_b), 32'h0000);
      check("oor_pre_valid_b", 32'(if1.valid_b), 32'h0);
      tick();
      if1.write = 1'b0;
      #1;
      check("oor_data_b", 32'(if1.data_out_b), 32'h0000);
      check("oor_valid_b", 32'(if1.valid_b), 32'h0);
      check("oor_data_a6", 32'(if1.data_out_a), 32'h0000);
      check("oor_valid_a6", 32'(if1.valid_a), 32'h0);
      check("oor_written", 32'(if1.written), 32'h05);
      for (int i = 1; i < 6; i++) begin
         if1.readnum_a = 3'(i);
         #1;
         check($sformatf("oor_keep_r%0d", i), 32'(if1.data_out_a),
               (i == 2) ? 32'hBEEF : 32'h0000);
      end

      // 6. Reset wins over a simultaneous write.
      if0.write = 1'b1; if0.writenum = 3'd1; if0.data_in = 16'h0011;
      tick();
      if0.write = 1'b0; if0.readnum_a = 3'd1;
      #1;
      check("pre_rst_r1", 32'(if0.data_out_a), 32'h0011);
      reset = 1'b1;
      if0.write = 1'b1; if0.writenum = 3'd1; if0.data_in = 16'h0042;
      tick();
      reset = 1'b0;
      if0.write = 1'b0;
      if0.readnum_b = 3'd3;
      #1;
      check("rstwr_r1_data", 32'(if0.data_out_a), 32'h0000);
      check("rstwr_r1_valid", 32'(if0.valid_a), 32'h0);
      check("rstwr_r3_data", 32'(if0.data_out_b), 32'h0000);
      check("rstwr_written", 32'(if0.written), 32'h00);
      check("rstwr_dut1_written", 32'(if1.written), 32'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
